// File: rtl/logic_op_arbiter_pkg.sv
// Shared opcode encodings, widths and slot state type for the logic-op arbiter.
// Optional statistics counter is enabled with LOGIC_ARB_STATS_EN.
package logic_arb_pkg;

  localparam int OPW     = 2;
  localparam int STATS_W = 16;

  localparam logic [OPW-1:0] OP_AND  = 2'b00;
  localparam logic [OPW-1:0] OP_OR   = 2'b01;
  localparam logic [OPW-1:0] OP_XOR  = 2'b10;
  localparam logic [OPW-1:0] OP_NAND = 2'b11;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/logic_op_arbiter_if.sv
// Request/result bundle between client blocks and the shared logic unit.
// master = requester/sink side, slave = arbiter side.
interface logic_op_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  import logic_arb_pkg::*;

  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [OPW*NREQ-1:0]   req_op;
  logic [WIDTH*NREQ-1:0] req_in1;
  logic [WIDTH*NREQ-1:0] req_in2;
  logic                  res_valid;
  logic                  res_ready;
  logic [IDW-1:0]        res_id;
  logic [OPW-1:0]        res_op;
  logic [WIDTH-1:0]      res_out;

  modport master (
    output req_valid, req_op, req_in1, req_in2, res_ready,
    input  req_ready, res_valid, res_id, res_op, res_out
  );

  modport slave (
    input  req_valid, req_op, req_in1, req_in2, res_ready,
    output req_ready, res_valid, res_id, res_op, res_out
  );

endinterface

// File: rtl/logic_op_arbiter_rr_arbiter.sv
// Combinational round-robin grant: first asserted request at or after ptr,
// wrapping modulo NREQ. Grant is all-zero when en is low.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant
);

  always_comb begin
    logic [IDW-1:0] v_idx;
    logic           v_found;
    grant   = '0;
    v_idx   = '0;
    v_found = 1'b0;
    if (en) begin
      for (int k = 0; k < NREQ; k++) begin
        v_idx = IDW'((int'(ptr) + k) % NREQ);
        if (!v_found && req[v_idx]) begin
          grant[v_idx] = 1'b1;
          v_found      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin sharing of one AND/OR/XOR/NAND unit with a single-entry result slot.
// Define LOGIC_ARB_STATS_EN to add the 16-bit op_count transfer counter port.
module logic_op_arbiter
  import logic_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  logic_op_arbiter_if.slave    bus
`ifdef LOGIC_ARB_STATS_EN
  ,
  output logic [STATS_W-1:0]   op_count
`endif
);

  localparam int IDW = $clog2(NREQ);

  function automatic logic [WIDTH-1:0] f_logic_op(input logic [OPW-1:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  slot_state_e      r_state;
  slot_state_e      w_state_nxt;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_id;
  logic [OPW-1:0]   r_op;
  logic [WIDTH-1:0] r_out;

  logic             w_res_valid;
  logic             w_accept_en;
  logic [NREQ-1:0]  w_grant;
  logic             w_xfer;
  logic [IDW-1:0]   w_gid;
  logic [IDW-1:0]   w_ptr_nxt;
  logic [OPW-1:0]   w_sel_op;
  logic [WIDTH-1:0] w_sel_in1;
  logic [WIDTH-1:0] w_sel_in2;

  // Grant is also gated by rst_n so nothing is offered while reset is held.
  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req   (bus.req_valid),
    .ptr   (r_ptr),
    .en    (w_accept_en),
    .grant (w_grant)
  );

  assign w_xfer = |(w_grant & bus.req_valid);

  always_comb begin
    w_gid     = '0;
    w_sel_op  = '0;
    w_sel_in1 = '0;
    w_sel_in2 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_gid     = IDW'(i);
        w_sel_op  = bus.req_op[OPW*i +: OPW];
        w_sel_in1 = bus.req_in1[WIDTH*i +: WIDTH];
        w_sel_in2 = bus.req_in2[WIDTH*i +: WIDTH];
      end
    end
  end

  assign w_ptr_nxt = (w_gid == IDW'(NREQ - 1)) ? '0 : w_gid + IDW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= SLOT_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SLOT_EMPTY: if (w_xfer) w_state_nxt = SLOT_FULL;
      SLOT_FULL:  if (!w_xfer && bus.res_ready) w_state_nxt = SLOT_EMPTY;
      default:    w_state_nxt = SLOT_EMPTY;
    endcase
  end

  always_comb begin
    w_res_valid = (r_state == SLOT_FULL);
    w_accept_en = rst_n && (!w_res_valid || bus.res_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
      r_id  <= '0;
      r_op  <= '0;
      r_out <= '0;
    end else if (w_xfer) begin
      r_ptr <= w_ptr_nxt;
      r_id  <= w_gid;
      r_op  <= w_sel_op;
      r_out <= f_logic_op(w_sel_op, w_sel_in1, w_sel_in2);
    end
  end

`ifdef LOGIC_ARB_STATS_EN
  logic [STATS_W-1:0] r_op_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_op_count <= '0;
    else if (w_xfer) r_op_count <= r_op_count + STATS_W'(1);
  end

  assign op_count = r_op_count;
`endif

  assign bus.req_ready = w_grant;
  assign bus.res_valid = w_res_valid;
  assign bus.res_id    = r_id;
  assign bus.res_op    = r_op;
  assign bus.res_out   = r_out;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Directed bench for logic_op_arbiter (NREQ=4, WIDTH=8); op_count checks
// are compiled in only when LOGIC_ARB_STATS_EN is defined.
module tb_logic_op_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic_op_arbiter_if #(.NREQ(4), .WIDTH(8)) bus ();

`ifdef LOGIC_ARB_STATS_EN
  logic [15:0] op_count;
`endif

  logic_op_arbiter #(.NREQ(4), .WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus)
`ifdef LOGIC_ARB_STATS_EN
    ,
    .op_count (op_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.req_op[2*i +: 2]  = op;
    bus.req_in1[8*i +: 8] = a;
    bus.req_in2[8*i +: 8] = b;
  endtask

  task automatic single(input int i, input logic [1:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] exp_out);
    set_req(i, op, a, b);
    bus.req_valid = 4'b0001 << i;
    #1;
    chk("single_ready", bus.req_ready, 32'(4'b0001 << i));
    @(posedge clk); #1;
    bus.req_valid = '0;
    chk("single_valid", bus.res_valid, 1);
    chk("single_id", bus.res_id, i);
    chk("single_op", bus.res_op, op);
    chk("single_out", bus.res_out, exp_out);
  endtask

  initial begin
    int         gseq [6];
    logic [7:0] aout [4];
    checks         = 0;
    failures       = 0;
    gseq           = '{0, 1, 2, 3, 0, 1};
    aout           = '{8'h30, 8'hFC, 8'hCC, 8'hCF};
    rst_n          = 1'b0;
    bus.req_valid  = 4'hF;
    bus.req_op     = '0;
    bus.req_in1    = '0;
    bus.req_in2    = '0;
    bus.res_ready  = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", bus.res_valid, 0);
    chk("rst_id", bus.res_id, 0);
    chk("rst_op", bus.res_op, 0);
    chk("rst_out", bus.res_out, 0);
    chk("rst_ready", bus.req_ready, 0);

    bus.req_valid = '0;
    rst_n         = 1'b1;
    single(0, 2'b10, 8'hF0, 8'h3C, 8'hCC);
    single(1, 2'b11, 8'hFF, 8'h0F, 8'hF0);
    single(2, 2'b00, 8'hA5, 8'h0F, 8'h05);
    single(3, 2'b01, 8'hA0, 8'h05, 8'hA5);
    @(posedge clk); #1;
    chk("drain_valid", bus.res_valid, 0);

    set_req(0, 2'b00, 8'hF0, 8'h3C);
    set_req(1, 2'b01, 8'hF0, 8'h3C);
    set_req(2, 2'b10, 8'hF0, 8'h3C);
    set_req(3, 2'b11, 8'hF0, 8'h3C);
    bus.req_valid = 4'hF;
    #1;
    for (int k = 0; k < 6; k++) begin
      chk("rr_ready", bus.req_ready, 32'(4'b0001 << gseq[k]));
      @(posedge clk); #1;
      chk("rr_valid", bus.res_valid, 1);
      chk("rr_id", bus.res_id, gseq[k]);
      chk("rr_out", bus.res_out, aout[gseq[k]]);
    end

    bus.res_ready = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("hold_ready", bus.req_ready, 0);
      chk("hold_valid", bus.res_valid, 1);
      chk("hold_id", bus.res_id, 1);
      chk("hold_op", bus.res_op, 1);
      chk("hold_out", bus.res_out, 8'hFC);
      @(posedge clk); #1;
    end
    bus.res_ready = 1'b1;
    #1;
    chk("refill_ready", bus.req_ready, 4'b0100);
    @(posedge clk); #1;
    chk("refill_valid", bus.res_valid, 1);
    chk("refill_id", bus.res_id, 2);
    chk("refill_out", bus.res_out, 8'hCC);
    chk("refill_next_ready", bus.req_ready, 4'b1000);

    bus.res_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.res_valid, 0);
    chk("arst_id", bus.res_id, 0);
    chk("arst_out", bus.res_out, 0);
    chk("arst_ready", bus.req_ready, 0);
    @(posedge clk); #1;
    rst_n         = 1'b1;
    bus.res_ready = 1'b1;
    #1;
    chk("post_rst_ready", bus.req_ready, 4'b0001);
    @(posedge clk); #1;
    chk("post_rst_id", bus.res_id, 0);
    chk("post_rst_out", bus.res_out, 8'h30);
    chk("post_rst_next_ready", bus.req_ready, 4'b0010);

`ifdef LOGIC_ARB_STATS_EN
    chk("cnt_first", op_count, 1);
    repeat (299) @(posedge clk);
    #1;
    chk("cnt_300", op_count, 300);
    repeat (65236) @(posedge clk);
    #1;
    chk("cnt_wrap", op_count, 0);
`endif

    bus.req_valid = '0;
    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
